// File: rtl/scie_pkg.sv
// Shared definitions for the SCIE command sequencer: instruction encodings,
// FSM state type and the default data width.
package scie_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [31:0] INSN_COEF = 32'd11;
  localparam logic [31:0] INSN_PUSH = 32'd43;
  localparam logic [31:0] INSN_READ = 32'd91;

  typedef enum logic [2:0] {
    IDLE,
    COEF,
    PUSH,
    GAP,
    READ,
    CAPT
  } scie_seq_state_t;

endpackage

// File: rtl/scie_sequencer_if.sv
// Bundle of the coefficient, sample, result and SCIE issue signals of
// scie_sequencer; master = the sequencer, slave = fabric plus accelerator.
interface scie_sequencer_if #(
  parameter int NTAPS = 5,
  parameter int XLEN  = scie_pkg::XLEN_DEFAULT
);
  import scie_pkg::*;

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  // valid/ready: a transfer happens on a rising edge where both are high;
  // the producer holds valid and its payload stable until that edge.
  logic            io_coef_valid;
  logic            io_coef_ready;
  logic [IW-1:0]   io_coef_idx;
  logic [XLEN-1:0] io_coef_data;

  logic            io_in_valid;
  logic            io_in_ready;
  logic [XLEN-1:0] io_in_data;

  logic            io_out_valid;
  logic            io_out_ready;
  logic [XLEN-1:0] io_out_data;

  logic            io_scie_valid;
  logic [31:0]     io_scie_insn;
  logic [XLEN-1:0] io_scie_rs1;
  logic [XLEN-1:0] io_scie_rs2;
  logic [XLEN-1:0] io_scie_rd;

  logic            io_busy;
  scie_seq_state_t dbg_state;

  modport master (
    input  io_coef_valid, io_coef_idx, io_coef_data,
    input  io_in_valid, io_in_data,
    input  io_out_ready,
    input  io_scie_rd,
    output io_coef_ready, io_in_ready,
    output io_out_valid, io_out_data,
    output io_scie_valid, io_scie_insn, io_scie_rs1, io_scie_rs2,
    output io_busy, dbg_state
  );

  modport slave (
    output io_coef_valid, io_coef_idx, io_coef_data,
    output io_in_valid, io_in_data,
    output io_out_ready,
    output io_scie_rd,
    input  io_coef_ready, io_in_ready,
    input  io_out_valid, io_out_data,
    input  io_scie_valid, io_scie_insn, io_scie_rs1, io_scie_rs2,
    input  io_busy, dbg_state
  );

endinterface

// File: rtl/scie_sequencer.sv
// Issues COEF/PUSH/READ instructions to a SCIE pipelined FIR accelerator and
// returns each result on a valid/ready stream. SCIE_SEQ_PERF_EN adds perf counters.
module scie_sequencer
  import scie_pkg::*;
#(
  parameter int NTAPS = 5,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  scie_sequencer_if.master    bus
`ifdef SCIE_SEQ_PERF_EN
  ,
  output logic [31:0]         io_perf_samples,
  output logic [31:0]         io_perf_stall
`endif
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  scie_seq_state_t state_q, state_d;
  logic            scie_valid_q, scie_valid_d;
  logic [31:0]     insn_q, insn_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            pending_q, pending_d;

  logic            coef_ready;
  logic            in_ready;
  logic            coef_fire;
  logic            in_fire;
  logic            out_fire;
  logic [IW-1:0]   coef_idx;

  assign coef_idx   = bus.io_coef_idx;
  assign out_fire   = pending_q & bus.io_out_ready;
  assign coef_ready = (state_q == IDLE);
  // A result drained this very cycle no longer blocks the next sample,
  // which is what allows one sample every five cycles.
  assign in_ready   = (state_q == IDLE) & ~bus.io_coef_valid & (~pending_q | out_fire);
  assign coef_fire  = coef_ready & bus.io_coef_valid;
  assign in_fire    = in_ready & bus.io_in_valid;

  always_comb begin
    state_d      = state_q;
    scie_valid_d = 1'b0;
    insn_d       = insn_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    out_data_d   = out_data_q;
    pending_d    = pending_q & ~out_fire;
    case (state_q)
      IDLE: begin
        if (coef_fire) begin
          state_d      = COEF;
          scie_valid_d = 1'b1;
          insn_d       = INSN_COEF;
          rs1_d        = bus.io_coef_data;
          rs2_d        = XLEN'(coef_idx);
        end else if (in_fire) begin
          state_d      = PUSH;
          scie_valid_d = 1'b1;
          insn_d       = INSN_PUSH;
          rs1_d        = bus.io_in_data;
        end
      end
      COEF: state_d = IDLE;
      PUSH: state_d = GAP;
      GAP: begin
        state_d      = READ;
        scie_valid_d = 1'b1;
        insn_d       = INSN_READ;
      end
      READ: begin
        // The accelerator presents rd one cycle after READ, so READ is held
        // for a second cycle while the result is captured.
        state_d      = CAPT;
        scie_valid_d = 1'b1;
        insn_d       = INSN_READ;
      end
      CAPT: begin
        state_d    = IDLE;
        out_data_d = bus.io_scie_rd;
        pending_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      scie_valid_q <= 1'b0;
      insn_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      out_data_q   <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scie_valid_q <= scie_valid_d;
      insn_q       <= insn_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      out_data_q   <= out_data_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.io_coef_ready = coef_ready;
  assign bus.io_in_ready   = in_ready;
  assign bus.io_out_valid  = pending_q;
  assign bus.io_out_data   = out_data_q;
  assign bus.io_scie_valid = scie_valid_q;
  assign bus.io_scie_insn  = insn_q;
  assign bus.io_scie_rs1   = rs1_q;
  assign bus.io_scie_rs2   = rs2_q;
  assign bus.io_busy       = (state_q != IDLE) | pending_q;
  assign bus.dbg_state     = state_q;

`ifdef SCIE_SEQ_PERF_EN
  logic [31:0] perf_samples_q, perf_samples_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_samples_d = perf_samples_q + {31'd0, (state_q == CAPT)};
    perf_stall_d   = perf_stall_q + {31'd0, (pending_q & ~bus.io_out_ready)};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_samples_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_samples_q <= perf_samples_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign io_perf_samples = perf_samples_q;
  assign io_perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_scie_sequencer.sv
// Bench for scie_sequencer with a behavioural SCIE FIR accelerator model;
// result data and latency are checked through an expected-value scoreboard.
module tb_scie_sequencer;
  import scie_pkg::*;

  localparam int NTAPS = 5;
  localparam int XLEN  = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  scie_sequencer_if #(.NTAPS(NTAPS), .XLEN(XLEN)) bus ();

`ifdef SCIE_SEQ_PERF_EN
  logic [31:0] perf_samples;
  logic [31:0] perf_stall;
`endif

  scie_sequencer #(.NTAPS(NTAPS), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef SCIE_SEQ_PERF_EN
    ,
    .io_perf_samples (perf_samples),
    .io_perf_stall   (perf_stall)
`endif
  );

  // ---------------- accelerator model ----------------
  // rd is only meaningful in the cycle after a READ issue; otherwise junk.
  logic signed [XLEN-1:0] acc_coef [8];
  logic signed [XLEN-1:0] acc_hist [NTAPS];
  logic signed [XLEN-1:0] acc_sum;
  logic                   rd_ok_q;

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) acc_coef[k] <= '0;
      for (int k = 0; k < NTAPS; k++) acc_hist[k] <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      rd_ok_q <= bus.io_scie_valid && (bus.io_scie_insn == INSN_READ);
      if (bus.io_scie_valid && bus.io_scie_insn == INSN_COEF)
        acc_coef[bus.io_scie_rs2[2:0]] <= bus.io_scie_rs1;
      if (bus.io_scie_valid && bus.io_scie_insn == INSN_PUSH) begin
        acc_hist[0] <= bus.io_scie_rs1;
        for (int k = 1; k < NTAPS; k++) acc_hist[k] <= acc_hist[k-1];
      end
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < NTAPS; k++) acc_sum = acc_sum + acc_coef[k] * acc_hist[k];
    bus.io_scie_rd = rd_ok_q ? acc_sum : 32'hDEAD_BEEF;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  logic            prev_ov = 1'b0;

  always @(negedge clock) begin
    #2;
    if (reset) begin
      prev_ov <= 1'b0;
    end else begin
      if (bus.io_out_valid && !prev_ov) begin
        if (lat_q.size() == 0) check("latency_unexpected", 64'd1, 64'd0);
        else check("out_latency", 64'(cyc), 64'(lat_q.pop_front()));
      end
      if (bus.io_out_valid && bus.io_out_ready) begin
        if (exp_q.size() == 0) check("out_unexpected", 64'(bus.io_out_data), 64'd0);
        else check("out_data", 64'(bus.io_out_data), 64'(exp_q.pop_front()));
      end
      prev_ov <= bus.io_out_valid;
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_coef(input int idx, input logic [XLEN-1:0] d);
    int n = 0;
    bus.io_coef_idx   = 3'(idx);
    bus.io_coef_data  = d;
    bus.io_coef_valid = 1'b1;
    #1;
    while (!bus.io_coef_ready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 50) check("coef_ready_timeout", 64'(bus.io_coef_ready), 64'd1);
    @(negedge clock);
    bus.io_coef_valid = 1'b0;
    check("coef_valid", 64'(bus.io_scie_valid), 64'd1);
    check("coef_insn", 64'(bus.io_scie_insn), 64'(INSN_COEF));
    check("coef_rs1", 64'(bus.io_scie_rs1), 64'(d));
    check("coef_rs2", 64'(bus.io_scie_rs2), 64'(idx));
    @(negedge clock);
    check("coef_one_cycle", 64'(bus.io_scie_valid), 64'd0);
  endtask

  task automatic send_sample(input logic [XLEN-1:0] d, input logic [XLEN-1:0] e,
                             output int acc_cyc);
    int n = 0;
    bus.io_in_data  = d;
    bus.io_in_valid = 1'b1;
    #1;
    while (!bus.io_in_ready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 50) check("in_ready_timeout", 64'(bus.io_in_ready), 64'd1);
    acc_cyc = cyc;
    exp_q.push_back(e);
    lat_q.push_back(cyc + 5);
    @(negedge clock);
    bus.io_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.io_busy) && n < 100) begin
      @(negedge clock); n++;
    end
    check("drain_busy", 64'(bus.io_busy), 64'd0);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int              idx;
    logic [XLEN-1:0] val;
  } coef_vec_t;

  typedef struct {
    logic [XLEN-1:0] din;
    logic [XLEN-1:0] dout;
  } samp_vec_t;

  coef_vec_t coefs[5];
  samp_vec_t samps[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev_acc, n, reads;

    coefs[0] = '{0, -32'sd38};
    coefs[1] = '{1, -32'sd98};
    coefs[2] = '{2, -32'sd80};
    coefs[3] = '{3, -32'sd83};
    coefs[4] = '{4, -32'sd66};
    samps[0] = '{-32'sd67, 32'sd2546};
    samps[1] = '{-32'sd93, 32'sd10100};
    samps[2] = '{-32'sd39, 32'sd15956};
    samps[3] = '{-32'sd44, 32'sd18495};
    samps[4] = '{-32'sd63, 32'sd21967};

    bus.io_coef_valid = 1'b0;
    bus.io_coef_idx   = '0;
    bus.io_coef_data  = '0;
    bus.io_in_valid   = 1'b0;
    bus.io_in_data    = '0;
    bus.io_out_ready  = 1'b1;
    prev_acc = 0;

    // reset values
    repeat (3) @(negedge clock);
    check("rst_scie_valid", 64'(bus.io_scie_valid), 64'd0);
    check("rst_insn", 64'(bus.io_scie_insn), 64'd0);
    check("rst_rs1", 64'(bus.io_scie_rs1), 64'd0);
    check("rst_rs2", 64'(bus.io_scie_rs2), 64'd0);
    check("rst_out_valid", 64'(bus.io_out_valid), 64'd0);
    check("rst_out_data", 64'(bus.io_out_data), 64'd0);
    check("rst_busy", 64'(bus.io_busy), 64'd0);
    check("rst_coef_ready", 64'(bus.io_coef_ready), 64'd1);
    check("rst_in_ready", 64'(bus.io_in_ready), 64'd1);
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    reset = 1'b0;

    // coefficient load
    for (int i = 0; i < 5; i++) send_coef(coefs[i].idx, coefs[i].val);

    // sustained streaming
    for (int i = 0; i < 5; i++) begin
      send_sample(samps[i].din, samps[i].dout, acc);
      if (i > 0) check("throughput", 64'(acc - prev_acc), 64'd5);
      prev_acc = acc;
    end
    check("busy_in_flight", 64'(bus.io_busy), 64'd1);
    wait_drain();

    // backpressure after first result
    pulse_reset();
    for (int i = 0; i < 5; i++) send_coef(coefs[i].idx, coefs[i].val);
    bus.io_out_ready = 1'b0;
    send_sample(samps[0].din, samps[0].dout, acc);
    n = 0;
    while (!bus.io_out_valid && n < 20) begin
      @(negedge clock); n++;
    end
    for (int s = 0; s < 3; s++) begin
      check("stall_out_valid", 64'(bus.io_out_valid), 64'd1);
      check("stall_out_data", 64'(bus.io_out_data), 64'(samps[0].dout));
      check("stall_in_ready", 64'(bus.io_in_ready), 64'd0);
      @(negedge clock);
    end
    bus.io_out_ready = 1'b1;
    for (int i = 1; i < 5; i++) send_sample(samps[i].din, samps[i].dout, acc);
    wait_drain();
`ifdef SCIE_SEQ_PERF_EN
    check("perf_samples", 64'(perf_samples), 64'd5);
    check("perf_stall", 64'(perf_stall), 64'd3);
`endif

    // coefficient and sample offered together
    bus.io_coef_idx   = 3'd0;
    bus.io_coef_data  = -32'sd38;
    bus.io_coef_valid = 1'b1;
    bus.io_in_data    = 32'sd10;
    bus.io_in_valid   = 1'b1;
    #1;
    check("prio_in_ready", 64'(bus.io_in_ready), 64'd0);
    check("prio_coef_ready", 64'(bus.io_coef_ready), 64'd1);
    @(negedge clock);
    bus.io_coef_valid = 1'b0;
    check("prio_coef_insn", 64'(bus.io_scie_insn), 64'(INSN_COEF));
    check("prio_coef_valid", 64'(bus.io_scie_valid), 64'd1);
    @(negedge clock);
    #1;
    check("prio_in_ready_later", 64'(bus.io_in_ready), 64'd1);
    exp_q.push_back(32'sd18689);
    lat_q.push_back(cyc + 5);
    @(negedge clock);
    bus.io_in_valid = 1'b0;
    check("prio_push_insn", 64'(bus.io_scie_insn), 64'(INSN_PUSH));
    check("prio_push_rs1", 64'(bus.io_scie_rs1), 64'd10);
    wait_drain();

    // reset while in GAP
    bus.io_in_data  = 32'sd7;
    bus.io_in_valid = 1'b1;
    @(negedge clock);
    bus.io_in_valid = 1'b0;
    check("gap_push_state", 64'(bus.dbg_state), 64'(PUSH));
    @(negedge clock);
    check("gap_state", 64'(bus.dbg_state), 64'(GAP));
    check("gap_valid", 64'(bus.io_scie_valid), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("gaprst_state", 64'(bus.dbg_state), 64'(IDLE));
    check("gaprst_scie_valid", 64'(bus.io_scie_valid), 64'd0);
    check("gaprst_out_valid", 64'(bus.io_out_valid), 64'd0);
    check("gaprst_insn", 64'(bus.io_scie_insn), 64'd0);
    check("gaprst_rs1", 64'(bus.io_scie_rs1), 64'd0);
    reads = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.io_scie_valid && bus.io_scie_insn == INSN_READ) reads++;
    end
    check("gaprst_no_read", 64'(reads), 64'd0);
    check("gaprst_busy", 64'(bus.io_busy), 64'd0);

    // out-of-range tap index is forwarded untouched
    send_coef(7, 32'd123);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
